seven_seg_scanner: RTL and testbench
====================================

Name: seven_seg_scanner

Overview:
- Output end of the Basys 3 user interface.
- Takes the four 5-bit character codes that the control FSM produces (display_d3..display_d0) and drives the time-multiplexed, active-low 7-segment display (seg/an).
- Provides per-digit blinking and whole-display blanking.
- Sits between the top-level control/result mux and the board pins.

Parameters:
- REFRESH_DIV, 100000, clock cycles per digit slot (1 ms at 100 MHz); must be > GHOST_GUARD+1.
- GHOST_GUARD, 2, cycles at the start of each slot during which all anodes are off; must be ≥1.
- BLINK_DIV, 25000000, cycles per blink half-period.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  asynchronous, active-low reset.
- display_d0  in  5  character code, rightmost digit (an[0]).
- display_d1  in  5  character code, digit 1.
- display_d2  in  5  character code, digit 2.
- display_d3  in  5  character code, leftmost digit (an[3]).
- blank_all  in  1  forces all anodes off.
- blink_mask  in  4  bit i=1 blinks digit i.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- an  out  4  anodes, active-low, one-hot when lit.
- frame_tick  out  1  one-cycle pulse when digit index wraps 3→0.

Behaviour:
- Reset (async, rst_n=0):
  - an=4'hF, seg=7'h7F, frame_tick=0.
  - cnt=0, idx=0, blink counter=0, blink_phase=0, latched codes=5'h14.
- Slot counter, per cycle:
  - If cnt==REFRESH_DIV-1: cnt←0, idx←idx+1 (mod 4), and frame_tick←1 when idx==3.
  - Otherwise cnt←cnt+1 and frame_tick←0.
- Code latch:
  - When cnt==0, lat[idx]←display_d[idx].
  - Input changes mid-slot are not visible until that digit's next slot; no tearing.
- Registered outputs, 1-cycle latency from (idx,cnt):
  - an=4'hF if cnt<GHOST_GUARD or blank_all=1; otherwise ~(1<<idx).
  - seg=7'h7F if blink_phase=1 and blink_mask[idx]=1; otherwise decode(lat[idx]).
- blank_all:
  - Affects an only.
  - Counters, latching, frame_tick and blink keep running.
  - Deassertion resumes on the next edge with no resync.
- Blink:
  - Free-running counter 0..BLINK_DIV-1.
  - blink_phase toggles on each wrap.
  - Independent of the slot counter.
- Decode table (code→seg hex):
  - 00→40, 01→79, 02→24, 03→30, 04→19, 05→12, 06→02, 07→78
  - 08→00, 09→10, 0A→08, 0B→03, 0C→46, 0D→21, 0E→06, 0F→0E
  - 10 'n'→2B, 11 'r'→2F, 12 'L'→47, 13 'H'→09, 14 blank→7F, 15 'I'→4F
  - 16..1F→3F (dash = invalid code)
- Sweep: one full sweep takes 4·REFRESH_DIV cycles; frame_tick period equals this.
- Reset mid-slot: outputs go to reset values immediately (asynchronously); the first lit anode after release is again an[0].
- No other inputs are synchronised; all inputs come from the clk domain.

Test Plan (REFRESH_DIV=8, GHOST_GUARD=2, BLINK_DIV=64, display_d*=5'h14 unless stated):
- Reset release → an=F for the first 2 edges. an=1110 first appears on edge 3 and holds 6 cycles. Then an=F for 2 cycles, then an=1101 on edge 11. frame_tick pulses on the edge where cnt wraps in slot 3, every 32 cycles.
- d3..d0 = 12,0D,0A,13 ("LdAH") held → lit slots show an0:seg=09, an1:08, an2:21, an3:47. Codes 0C,00,10,0F ("COnF") → 47 rows replaced by 46,40,2B,0E.
- Change display_d0 from 04 to 0A while an=1110 is lit → seg stays 19 for the rest of that slot and shows 08 on the next an[0] slot.
- blink_mask=0001, d0=05 → an[0] slots show seg=12 during phase 0 and seg=7F during phase 1 (64-cycle halves). Digits 1–3 show unchanged segments throughout.
- blank_all=1 for 40 cycles → an=F from the next edge; frame_tick still pulses. d1=1F shows seg=3F once blank_all is released.
- rst_n pulled low mid-slot with an=1011 → an=F and seg=7F in the same timestep without a clock. After release, the sequence restarts at an[0].

Source files
------------

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed driver for a 4-digit, active-low 7-segment display.
// Each digit owns a slot of REFRESH_DIV cycles. The first GHOST_GUARD cycles of a
// slot keep all anodes off while segments settle. Character codes are latched
// once per slot, at cnt==0, so a mid-slot input change never tears a digit.
module seven_seg_scanner #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned GHOST_GUARD = 2,
    parameter int unsigned BLINK_DIV   = 25000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] display_d0,
    input  logic [4:0] display_d1,
    input  logic [4:0] display_d2,
    input  logic [4:0] display_d3,
    input  logic       blank_all,
    input  logic [3:0] blink_mask,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       frame_tick
);

    localparam int unsigned CNT_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0]   GUARD      = CNT_W'(GHOST_GUARD);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    localparam logic [4:0] CODE_BLANK = 5'h14;
    localparam logic [6:0] SEG_OFF    = 7'h7F;

    // Character code to {g,f,e,d,c,b,a}, active-low; unknown codes show a dash.
    function automatic logic [6:0] decode(input logic [4:0] code);
        logic [6:0] s;
        case (code)
            5'h00:   s = 7'h40;
            5'h01:   s = 7'h79;
            5'h02:   s = 7'h24;
            5'h03:   s = 7'h30;
            5'h04:   s = 7'h19;
            5'h05:   s = 7'h12;
            5'h06:   s = 7'h02;
            5'h07:   s = 7'h78;
            5'h08:   s = 7'h00;
            5'h09:   s = 7'h10;
            5'h0A:   s = 7'h08;
            5'h0B:   s = 7'h03;
            5'h0C:   s = 7'h46;
            5'h0D:   s = 7'h21;
            5'h0E:   s = 7'h06;
            5'h0F:   s = 7'h0E;
            5'h10:   s = 7'h2B;
            5'h11:   s = 7'h2F;
            5'h12:   s = 7'h47;
            5'h13:   s = 7'h09;
            5'h14:   s = 7'h7F;
            5'h15:   s = 7'h4F;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         idx_q, idx_d;
    logic               frame_tick_q, frame_tick_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_phase_q, blink_phase_d;
    logic [3:0][4:0]    lat_q, lat_d;
    logic [3:0]         an_q, an_d;
    logic [6:0]         seg_q, seg_d;
    logic [3:0][4:0]    disp;
    logic               slot_wrap;

    // Slot counter, digit index and end-of-sweep pulse.
    always_comb begin
        slot_wrap    = (cnt_q == CNT_LAST);
        cnt_d        = slot_wrap ? '0 : cnt_q + CNT_W'(1);
        idx_d        = slot_wrap ? idx_q + 2'd1 : idx_q;
        frame_tick_d = slot_wrap && (idx_q == 2'd3);
    end

    // Free-running blink timebase, unrelated to the slot counter.
    always_comb begin
        if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end else begin
            blink_cnt_d   = blink_cnt_q + BLINK_W'(1);
            blink_phase_d = blink_phase_q;
        end
    end

    // Capture the active digit's code at the start of its slot only.
    always_comb begin
        disp  = {display_d3, display_d2, display_d1, display_d0};
        lat_d = lat_q;
        if (cnt_q == '0) begin
            lat_d[idx_q] = disp[idx_q];
        end
    end

    // Output decode; seg reads the latch, which is already refreshed once the guard ends.
    always_comb begin
        if ((cnt_q < GUARD) || blank_all) begin
            an_d = 4'hF;
        end else begin
            an_d = ~(4'b0001 << idx_q);
        end
        if (blink_phase_q && blink_mask[idx_q]) begin
            seg_d = SEG_OFF;
        end else begin
            seg_d = decode(lat_q[idx_q]);
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            frame_tick_q  <= 1'b0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            lat_q         <= {4{CODE_BLANK}};
            an_q          <= 4'hF;
            seg_q         <= SEG_OFF;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            frame_tick_q  <= frame_tick_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            lat_q         <= lat_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner with small dividers. Expected outputs come from
// edge-count arithmetic (slot, digit, blink half) plus a per-digit latched-code table.
module tb_seven_seg_scanner;

    localparam int unsigned RD = 8;
    localparam int unsigned GG = 2;
    localparam int unsigned BD = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] display_d0, display_d1, display_d2, display_d3;
    logic       blank_all;
    logic [3:0] blink_mask;
    logic [6:0] seg;
    logic [3:0] an;
    logic       frame_tick;

    int          n_cmp = 0;
    int          n_err = 0;
    int unsigned n_edges = 0;
    logic [4:0]  mlat [4];
    logic [6:0]  dec_tab [32];
    logic [6:0]  exp_seg;
    logic [3:0]  exp_an;
    logic        exp_ft;
    bit          found;

    always #5 clk = ~clk;

    seven_seg_scanner #(
        .REFRESH_DIV(RD),
        .GHOST_GUARD(GG),
        .BLINK_DIV  (BD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .display_d0(display_d0),
        .display_d1(display_d1),
        .display_d2(display_d2),
        .display_d3(display_d3),
        .blank_all (blank_all),
        .blink_mask(blink_mask),
        .seg       (seg),
        .an        (an),
        .frame_tick(frame_tick)
    );

    function automatic logic [4:0] din(input int unsigned i);
        case (i)
            0:       return display_d0;
            1:       return display_d1;
            2:       return display_d2;
            default: return display_d3;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h (edge %0d)", tag, obs, expv, n_edges);
        end
    endtask

    task automatic model_reset();
        n_edges = 0;
        for (int i = 0; i < 4; i++) mlat[i] = 5'h14;
    endtask

    // One clock edge: predict from the inputs seen at the edge, then compare 1 time unit later.
    task automatic step();
        int unsigned cnt, idx, ph;
        @(posedge clk);
        cnt = n_edges % RD;
        idx = (n_edges / RD) % 4;
        ph  = (n_edges / BD) % 2;
        exp_an  = (cnt < GG || blank_all) ? 4'hF : 4'(~(4'b0001 << idx));
        exp_seg = (ph == 1 && blink_mask[idx]) ? 7'h7F : dec_tab[mlat[idx]];
        exp_ft  = ((n_edges % (4 * RD)) == (4 * RD - 1));
        if (cnt == 0) mlat[idx] = din(idx);
        n_edges++;
        #1;
        chk("an", {3'b000, an}, {3'b000, exp_an});
        chk("seg", seg, exp_seg);
        chk("frame_tick", {6'd0, frame_tick}, {6'd0, exp_ft});
    endtask

    task automatic set_digits(input logic [4:0] c3, input logic [4:0] c2,
                              input logic [4:0] c1, input logic [4:0] c0);
        display_d3 = c3;
        display_d2 = c2;
        display_d1 = c1;
        display_d0 = c0;
    endtask

    initial begin
        for (int i = 16; i < 32; i++) dec_tab[i] = 7'h3F;
        dec_tab[0]  = 7'h40; dec_tab[1]  = 7'h79; dec_tab[2]  = 7'h24; dec_tab[3]  = 7'h30;
        dec_tab[4]  = 7'h19; dec_tab[5]  = 7'h12; dec_tab[6]  = 7'h02; dec_tab[7]  = 7'h78;
        dec_tab[8]  = 7'h00; dec_tab[9]  = 7'h10; dec_tab[10] = 7'h08; dec_tab[11] = 7'h03;
        dec_tab[12] = 7'h46; dec_tab[13] = 7'h21; dec_tab[14] = 7'h06; dec_tab[15] = 7'h0E;
        dec_tab[16] = 7'h2B; dec_tab[17] = 7'h2F; dec_tab[18] = 7'h47; dec_tab[19] = 7'h09;
        dec_tab[20] = 7'h7F; dec_tab[21] = 7'h4F;

        set_digits(5'h14, 5'h14, 5'h14, 5'h14);
        blank_all  = 1'b0;
        blink_mask = 4'h0;
        rst_n      = 1'b0;
        model_reset();

        // Held in reset across clock edges.
        repeat (3) @(posedge clk);
        #1;
        chk("reset_an", {3'b000, an}, 7'h0F);
        chk("reset_seg", seg, 7'h7F);
        chk("reset_ft", {6'd0, frame_tick}, 7'h00);
        rst_n = 1'b1;

        // Blank codes: guard timing, slot order, frame_tick cadence.
        repeat (80) step();

        // "LdAH" then "COnF".
        set_digits(5'h12, 5'h0D, 5'h0A, 5'h13);
        repeat (64) step();
        set_digits(5'h0C, 5'h00, 5'h10, 5'h0F);
        repeat (64) step();

        // Change digit 0 while it is lit: no effect until its next slot.
        display_d0 = 5'h04;
        repeat (32) step();
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (an === 4'b1110) found = 1'b1;
        end
        chk("found_an0_slot", {6'd0, found}, 7'h01);
        display_d0 = 5'h0A;
        repeat (40) step();

        // Blink digit 0 across several blink half-periods.
        blink_mask = 4'b0001;
        display_d0 = 5'h05;
        repeat (256) step();
        blink_mask = 4'h0;

        // Whole-display blanking, then an invalid code on digit 1.
        blank_all = 1'b1;
        repeat (40) step();
        blank_all  = 1'b0;
        display_d1 = 5'h1F;
        repeat (40) step();

        // Randomised codes, blink mask and blanking.
        repeat (3000) begin
            if ($urandom_range(15) == 0) begin
                case ($urandom_range(3))
                    0:       display_d0 = 5'($urandom);
                    1:       display_d1 = 5'($urandom);
                    2:       display_d2 = 5'($urandom);
                    default: display_d3 = 5'($urandom);
                endcase
            end
            if ($urandom_range(63) == 0) blink_mask = 4'($urandom);
            if ($urandom_range(31) == 0) blank_all = ~blank_all;
            step();
        end
        blank_all  = 1'b0;
        blink_mask = 4'h0;

        // Asynchronous reset in the middle of a lit digit-2 slot.
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            step();
            if (an === 4'b1011) found = 1'b1;
        end
        chk("found_an2_slot", {6'd0, found}, 7'h01);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_an", {3'b000, an}, 7'h0F);
        chk("async_rst_seg", seg, 7'h7F);
        chk("async_rst_ft", {6'd0, frame_tick}, 7'h00);
        repeat (2) @(posedge clk);
        #1;
        chk("held_rst_an", {3'b000, an}, 7'h0F);
        rst_n = 1'b1;
        model_reset();
        repeat (40) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
